if_fetch_unit: RTL and testbench

//  Instruction-fetch stage; producer side of the IF/ID pipeline register.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_skid_buf.sv | 60 ++++++
 rtl/if_fetch_unit.sv | 119 +++++++++++
 tb/tb_if_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: reset/NOP defaults, PC step, fetch FSM states
// and the {pc,inst} entry carried through the skid queue.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of fetched {pc,inst} words; entry 0 is always the head.
// Push and pop may occur in the same cycle; clear wins over both.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t ent0;
    fetch_entry_t ent1;
    logic [1:0]   cnt;
    logic         pop_ok;
    logic         push_ok;

    assign pop_ok  = pop & (cnt != 2'd0);
    assign push_ok = push & ((cnt != 2'd2) | pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= 2'd0;
        end else if (clear) begin
            cnt <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= din;
                    else             ent1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (cnt == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end else begin
                        ent0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = ent0;
    assign count = cnt;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake to imem,
// buffers words in a 2-entry skid queue and drives the IF/ID register controls.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_if,
    output logic [31:0] inst_if,
    output logic        if_valid,
    output logic        if_id_keep,
    output logic        if_id_flush,
    output logic [1:0]  fetch_state
);

    // imem handshake: imem_req, once high, stays high with imem_addr unchanged
    // until the cycle imem_ack is seen; ack may arrive in the same cycle as req,
    // and imem_rdata is only looked at in a cycle where imem_req & imem_ack.
    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_addr;
    logic         req_active;

    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic [1:0]   count;
    logic         push;
    logic         pop;
    logic         clear;

    always_comb begin
        imem_req = 1'b0;
        case (state)
            FETCH:   imem_req = req_active | (count <= 2'd1);
            DISCARD: imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    // A request that was not acked keeps its address even after pc moves to a redirect target.
    assign imem_addr = req_active ? req_addr : pc;

    assign clear      = redirect;
    assign pop        = (count != 2'd0) & ~id_stall & ~redirect;
    assign push       = (state == FETCH) & imem_req & imem_ack & ~redirect;
    assign push_entry = '{pc: imem_addr, inst: imem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            req_active <= 1'b0;
        end else if (redirect) begin
            pc <= word_align(redirect_pc);
            if (imem_req && !imem_ack) begin
                state      <= DISCARD;
                req_active <= 1'b1;
                req_addr   <= imem_addr;
            end else begin
                state      <= FETCH;
                req_active <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (imem_req) begin
                        if (imem_ack) begin
                            pc         <= imem_addr + PC_STEP;
                            req_active <= 1'b0;
                        end else begin
                            req_active <= 1'b1;
                            req_addr   <= imem_addr;
                        end
                    end
                end
                DISCARD: begin
                    // pc already holds the redirect target; just retire the stale request.
                    if (imem_ack) begin
                        state      <= FETCH;
                        req_active <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .head  (head),
        .count (count)
    );

    assign if_valid    = (count != 2'd0);
    assign pc_if       = if_valid ? head.pc : 32'h0000_0000;
    assign inst_if     = if_valid ? head.inst : NOP_INST;
    assign if_id_keep  = ~id_stall;
    assign if_id_flush = redirect & ~id_stall;
    assign fetch_state = state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: imem responder with variable latency, a transaction-level
// model of the delivered instruction stream, directed scenarios and a random phase.
module tb_if_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_if;
    logic [31:0] inst_if;
    logic        if_valid;
    logic        if_id_keep;
    logic        if_id_flush;
    logic [1:0]  fetch_state;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_if       (pc_if),
        .inst_if     (inst_if),
        .if_valid    (if_valid),
        .if_id_keep  (if_id_keep),
        .if_id_flush (if_id_flush),
        .fetch_state (fetch_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2008_0001 ^ (a * 32'h9E37_79B1);
    endfunction

    // ---------------- instruction memory responder ----------------
    int fixed_lat = 0;   // <0 selects a random latency of 0..3 cycles per request
    bit mem_hold  = 1'b0;
    int wait_cnt  = 0;
    int rand_lat  = 0;

    always @(negedge clk) begin
        #1;
        imem_rdata = mem_word(imem_addr);
        if (rst) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (imem_req && !mem_hold &&
                     wait_cnt >= ((fixed_lat < 0) ? rand_lat : fixed_lat)) begin
            imem_ack = 1'b1;
            wait_cnt = 0;
            rand_lat = $urandom_range(0, 3);
        end else begin
            imem_ack = 1'b0;
            if (imem_req) wait_cnt++;
        end
    end

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds PCs of words accepted from memory and not yet consumed by ID.
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    bit          stale     = 1'b0;
    bit          prev_hold = 1'b0;
    bit          started   = 1'b0;
    int          consumed  = 0;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_q.delete();
            exp_fetch = RESET_PC_DEF;
            stale     = 1'b0;
            prev_hold = 1'b0;
            started   = 1'b0;
        end else begin
            check("if_id_keep", if_id_keep, !id_stall);
            check("if_id_flush", if_id_flush, redirect && !id_stall);
            check("if_valid", if_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("pc_if", pc_if, exp_q[0]);
                check("inst_if", inst_if, mem_word(exp_q[0]));
            end else begin
                check("pc_if_empty", pc_if, 32'h0);
                check("inst_if_nop", inst_if, NOP_INST_DEF);
            end
            check("imem_req", imem_req, started && (prev_hold || exp_q.size() <= 1));
            if (imem_req)
                check("imem_addr", imem_addr, prev_hold ? prev_addr : exp_fetch);

            if (redirect) begin
                exp_q.delete();
                exp_fetch = redirect_pc & 32'hFFFF_FFFC;
                stale     = imem_req && !imem_ack;
            end else begin
                if (exp_q.size() != 0 && !id_stall) begin
                    void'(exp_q.pop_front());
                    consumed++;
                end
                if (imem_req && imem_ack) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        exp_q.push_back(exp_fetch);
                        exp_fetch = exp_fetch + 32'd4;
                    end
                end
            end
            prev_hold = imem_req && !imem_ack;
            prev_addr = imem_addr;
            started   = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_for_valid(input string name);
        int n = 0;
        @(negedge clk); #3;
        while (!if_valid && n < 50) begin
            @(negedge clk); #3;
            n++;
        end
        check(name, if_valid, 1'b1);
    endtask

    task automatic random_phase(input int cycles);
        fixed_lat = -1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            id_stall    = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | $urandom_range(0, 31))
                                                      : $urandom;
            mem_hold    = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        id_stall = 1'b0;
        redirect = 1'b0;
        mem_hold = 1'b0;
        fixed_lat = 0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #1 rst = 1'b1;
        #2;
        check("reset_imem_req", imem_req, 1'b0);
        check("reset_if_valid", if_valid, 1'b0);
        check("reset_pc_if", pc_if, 32'h0);
        check("reset_inst_if", inst_if, 32'h0);
        check("reset_state", fetch_state, IDLE);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Zero-latency memory, no stall: one word per cycle from RESET_PC.
        wait_for_valid("stream_start_valid");
        check("stream_pc0", pc_if, 32'h0000_0000);
        check("stream_inst0", inst_if, 32'h2008_0001);
        @(negedge clk); #3;
        check("stream_pc1", pc_if, 32'h0000_0004);
        check("stream_inst1", inst_if, 32'h58D5_E6C5);
        @(negedge clk); #3;
        check("stream_pc2", pc_if, 32'h0000_0008);
        check("stream_valid2", if_valid, 1'b1);

        // Stall for three cycles with memory always ready.
        @(negedge clk);
        id_stall = 1'b1;
        #3 check("stall_head1", pc_if, 32'h0000_000C);
        @(negedge clk); #3;
        @(negedge clk); #3;
        check("stall_req_drop", imem_req, 1'b0);
        check("stall_keep", if_id_keep, 1'b0);
        check("stall_head3", pc_if, 32'h0000_000C);
        @(negedge clk);
        id_stall = 1'b0;
        #3 check("release_pc0", pc_if, 32'h0000_000C);
        @(negedge clk); #3 check("release_pc1", pc_if, 32'h0000_0010);
        @(negedge clk); #3 check("release_pc2", pc_if, 32'h0000_0014);

        // Redirect while a request is waiting on memory.
        @(negedge clk);
        mem_hold = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0043;
        #3;
        check("disc_flush", if_id_flush, 1'b1);
        check("disc_addr0", imem_addr, 32'h0000_001C);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        check("disc_flush_pulse", if_id_flush, 1'b0);
        check("disc_req_held", imem_req, 1'b1);
        check("disc_addr1", imem_addr, 32'h0000_001C);
        @(negedge clk);
        mem_hold = 1'b0;
        #3 check("disc_addr2", imem_addr, 32'h0000_001C);
        @(negedge clk); #3;
        check("disc_next_req", imem_req, 1'b1);
        check("disc_next_addr", imem_addr, 32'h0000_0040);
        check("disc_dropped", if_valid, 1'b0);
        wait_for_valid("disc_target_valid");
        check("disc_target_pc", pc_if, 32'h0000_0040);

        // Redirect in the same cycle as an ack.
        repeat (2) @(negedge clk);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        #3 check("coinc_flush", if_id_flush, 1'b1);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        check("coinc_next_addr", imem_addr, 32'h0000_0100);
        check("coinc_empty", if_valid, 1'b0);
        @(negedge clk); #3;
        check("coinc_pc", pc_if, 32'h0000_0100);
        check("coinc_inst", inst_if, 32'h1771_B101);

        // PC wrap at the top of the address space.
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF9;
        @(negedge clk);
        redirect = 1'b0;
        #3 check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        @(negedge clk); #3 check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk); #3;
        check("wrap_addr2", imem_addr, 32'h0000_0000);
        check("wrap_pc_top", pc_if, 32'hFFFF_FFFC);
        @(negedge clk); #3;
        check("wrap_pc_zero", pc_if, 32'h0000_0000);
        check("wrap_inst_zero", inst_if, 32'h2008_0001);

        random_phase(1500);

        // Asynchronous reset in the middle of fetching.
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_req", imem_req, 1'b0);
        check("async_rst_valid", if_valid, 1'b0);
        check("async_rst_inst", inst_if, 32'h0);
        check("async_rst_pc", pc_if, 32'h0);
        @(posedge clk);
        #3 rst = 1'b0;
        begin
            int n = 0;
            @(negedge clk); #3;
            while (!imem_req && n < 10) begin
                @(negedge clk); #3;
                n++;
            end
            check("rst_first_req", imem_req, 1'b1);
            check("rst_first_addr", imem_addr, RESET_PC_DEF);
        end

        random_phase(1500);
        repeat (5) @(negedge clk);
        check("progress", consumed > 300, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got no end of test, expected finish before t=%0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
